waveform_analyzer: RTL and testbench



---
 rtl/waveform_analyzer.sv | 156 +++++++++++++++
 tb/tb_waveform_analyzer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/waveform_analyzer.sv
// Measures period, peak max/min and peak-to-peak of a sampled periodic waveform
// using hysteretic midscale rising-crossing detection; flags lock and timeout.
module waveform_analyzer #(
   parameter int DATA_W  = 8,
   parameter int MID     = 128,
   parameter int HYST    = 8,
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 4095
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] sample_in,
   input  logic              sample_valid,
   output logic [CNT_W-1:0]  period,
   output logic [DATA_W-1:0] max_val,
   output logic [DATA_W-1:0] min_val,
   output logic [DATA_W-1:0] pk_pk,
   output logic              result_valid,
   output logic              locked,
   output logic              timeout
);

   // Thresholds carry one extra bit so MID+HYST cannot wrap at full scale.
   localparam logic [DATA_W:0]  TH_HI  = (DATA_W+1)'(MID + HYST);
   localparam logic [DATA_W:0]  TH_LO  = (DATA_W+1)'(MID - HYST);
   localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

   typedef enum logic {SEARCH, MEASURE} state_t;

   state_t            state_reg, state_next;
   logic              hi_reg, hi_next;
   logic              init_reg, init_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic [DATA_W-1:0] run_max_reg, run_max_next;
   logic [DATA_W-1:0] run_min_reg, run_min_next;
   logic [CNT_W-1:0]  period_reg, period_next;
   logic [DATA_W-1:0] max_val_reg, max_val_next;
   logic [DATA_W-1:0] min_val_reg, min_val_next;
   logic [DATA_W-1:0] pk_pk_reg, pk_pk_next;
   logic              result_valid_reg, result_valid_next;
   logic              locked_reg, locked_next;
   logic              timeout_reg, timeout_next;

   logic [DATA_W:0]   sample_ext;
   logic              rise;
   logic [CNT_W-1:0]  cnt_inc;
   logic [DATA_W-1:0] upd_max, upd_min;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg        <= SEARCH;
         hi_reg           <= 1'b0;
         init_reg         <= 1'b0;
         cnt_reg          <= '0;
         run_max_reg      <= '0;
         run_min_reg      <= '0;
         period_reg       <= '0;
         max_val_reg      <= '0;
         min_val_reg      <= '0;
         pk_pk_reg        <= '0;
         result_valid_reg <= 1'b0;
         locked_reg       <= 1'b0;
         timeout_reg      <= 1'b0;
      end else begin
         state_reg        <= state_next;
         hi_reg           <= hi_next;
         init_reg         <= init_next;
         cnt_reg          <= cnt_next;
         run_max_reg      <= run_max_next;
         run_min_reg      <= run_min_next;
         period_reg       <= period_next;
         max_val_reg      <= max_val_next;
         min_val_reg      <= min_val_next;
         pk_pk_reg        <= pk_pk_next;
         result_valid_reg <= result_valid_next;
         locked_reg       <= locked_next;
         timeout_reg      <= timeout_next;
      end
   end

   always_comb begin
      sample_ext = {1'b0, sample_in};
      hi_next    = hi_reg;
      init_next  = init_reg;
      if (sample_valid) begin
         init_next = 1'b1;
         if (sample_ext >= TH_HI)
            hi_next = 1'b1;
         else if (sample_ext <= TH_LO)
            hi_next = 1'b0;
      end
      // The very first valid sample only establishes hi, it cannot be an event.
      rise    = sample_valid && init_reg && !hi_reg && hi_next;
      cnt_inc = cnt_reg + 1'b1;
      upd_max = (sample_in > run_max_reg) ? sample_in : run_max_reg;
      upd_min = (sample_in < run_min_reg) ? sample_in : run_min_reg;
   end

   always_comb begin
      state_next        = state_reg;
      cnt_next          = cnt_reg;
      run_max_next      = run_max_reg;
      run_min_next      = run_min_reg;
      period_next       = period_reg;
      max_val_next      = max_val_reg;
      min_val_next      = min_val_reg;
      pk_pk_next        = pk_pk_reg;
      result_valid_next = 1'b0;
      locked_next       = locked_reg;
      timeout_next      = 1'b0;
      case (state_reg)
         SEARCH: begin
            if (rise) begin
               cnt_next     = '0;
               run_max_next = sample_in;
               run_min_next = sample_in;
               state_next   = MEASURE;
            end
         end
         MEASURE: begin
            if (sample_valid) begin
               if (rise) begin
                  period_next       = cnt_inc;
                  max_val_next      = upd_max;
                  min_val_next      = upd_min;
                  pk_pk_next        = upd_max - upd_min;
                  result_valid_next = 1'b1;
                  locked_next       = 1'b1;
                  cnt_next          = '0;
                  run_max_next      = sample_in;
                  run_min_next      = sample_in;
               end else if (cnt_inc == TO_CNT) begin
                  // Published results are left untouched on loss of lock.
                  timeout_next = 1'b1;
                  locked_next  = 1'b0;
                  state_next   = SEARCH;
               end else begin
                  cnt_next     = cnt_inc;
                  run_max_next = upd_max;
                  run_min_next = upd_min;
               end
            end
         end
         default: state_next = SEARCH;
      endcase
   end

   assign period       = period_reg;
   assign max_val      = max_val_reg;
   assign min_val      = min_val_reg;
   assign pk_pk        = pk_pk_reg;
   assign result_valid = result_valid_reg;
   assign locked       = locked_reg;
   assign timeout      = timeout_reg;

endmodule

// File: tb/tb_waveform_analyzer.sv
// Scoreboard bench for waveform_analyzer: a reference model queues expected
// result/timeout pulses as samples are driven; a negedge monitor pops and compares.
module tb_waveform_analyzer;

   localparam int TIMEOUT = 4095;

   logic        clk;
   logic        rst;
   logic [7:0]  sample_in;
   logic        sample_valid;
   logic [15:0] period;
   logic [7:0]  max_val, min_val, pk_pk;
   logic        result_valid, locked, timeout;

   waveform_analyzer dut (
      .clk(clk), .reset(rst), .sample_in(sample_in), .sample_valid(sample_valid),
      .period(period), .max_val(max_val), .min_val(min_val), .pk_pk(pk_pk),
      .result_valid(result_valid), .locked(locked), .timeout(timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit is_to;
      int per;
      int mx;
      int mn;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model state
   bit   init_m, hi_m, meas_m;
   int   seg_n, seg_max, seg_min;
   int   last_per, last_mx, last_mn;

   // Monitor bookkeeping
   int   cyc = 0;
   int   rv_count = 0;
   int   to_count = 0;
   int   last_rv = 0;
   int   last_int = 0;
   bit   have_last = 0;

   int   sine_tab[32];

   task automatic check(input string tag, input int unsigned got, input int unsigned exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      init_m = 0; hi_m = 0; meas_m = 0;
      seg_n = 0; seg_max = 0; seg_min = 0;
      last_per = 0; last_mx = 0; last_mn = 0;
      exp_q.delete();
   endtask

   task automatic model_sample(input int s);
      bit new_hi;
      bit rise;
      exp_t e;
      new_hi = (s >= 136) ? 1'b1 : (s <= 120) ? 1'b0 : hi_m;
      rise   = init_m && !hi_m && new_hi;
      init_m = 1;
      hi_m   = new_hi;
      if (meas_m) begin
         seg_n++;
         if (s > seg_max) seg_max = s;
         if (s < seg_min) seg_min = s;
         if (rise) begin
            last_per = seg_n; last_mx = seg_max; last_mn = seg_min;
            e = '{is_to: 1'b0, per: last_per, mx: last_mx, mn: last_mn};
            exp_q.push_back(e);
            seg_n = 0; seg_max = s; seg_min = s;
         end else if (seg_n == TIMEOUT) begin
            e = '{is_to: 1'b1, per: last_per, mx: last_mx, mn: last_mn};
            exp_q.push_back(e);
            meas_m = 0;
         end
      end else if (rise) begin
         meas_m = 1;
         seg_n = 0; seg_max = s; seg_min = s;
      end
   endtask

   // Drive one cycle; called at posedge+1, returns at the next posedge+1.
   task automatic step(input int s, input bit v);
      sample_in    = 8'(s);
      sample_valid = v;
      if (v && !rst) model_sample(s);
      @(posedge clk);
      #1;
   endtask

   task automatic square(input int periods, input bit half_rate);
      for (int p = 0; p < periods; p++) begin
         for (int k = 0; k < 80; k++) begin
            step((k < 40) ? 200 : 50, 1'b1);
            if (half_rate) step((k < 40) ? 200 : 50, 1'b0);
         end
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_period"}, period, 0);
      check({tag, "_max"}, max_val, 0);
      check({tag, "_min"}, min_val, 0);
      check({tag, "_pkpk"}, pk_pk, 0);
      check({tag, "_rv"}, result_valid, 0);
      check({tag, "_locked"}, locked, 0);
      check({tag, "_timeout"}, timeout, 0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      cyc++;
      if (!rst && (result_valid || timeout)) begin
         if (exp_q.size() == 0) begin
            check("unexpected_pulse", {31'd0, result_valid}, {31'd0, timeout});
            check("unexpected_pulse_any", 1, 0);
         end else begin
            e = exp_q.pop_front();
            check("pulse_kind_to", timeout, e.is_to);
            check("pulse_kind_rv", result_valid, !e.is_to);
            check("period", period, e.per);
            check("max_val", max_val, e.mx);
            check("min_val", min_val, e.mn);
            check("pk_pk", pk_pk, e.mx - e.mn);
            check("locked", locked, !e.is_to);
            $display("pulse %s period=%0d max=%0d min=%0d pk=%0d locked=%0d",
                     e.is_to ? "timeout" : "result", period, max_val, min_val, pk_pk, locked);
         end
         if (result_valid) begin
            rv_count++;
            if (have_last) last_int = cyc - last_rv;
            last_rv   = cyc;
            have_last = 1;
         end
         if (timeout) to_count++;
      end
   end

   initial begin
      for (int i = 0; i < 32; i++) begin
         int v;
         v = $rtoi(127.5 + 127.5 * $sin(2.0 * 3.14159265358979 * i / 32.0) + 0.5);
         if (v > 255) v = 255;
         if (v < 0) v = 0;
         sine_tab[i] = v;
      end
      sample_in = 8'd0;
      sample_valid = 1'b0;
      model_reset();
      rst = 1'b1;
      #3;
      check_reset_outputs("por");
      @(posedge clk); #1;
      rst = 1'b0;

      // Full-rate square wave
      square(5, 1'b0);
      check("sq_interval", last_int, 80);
      check("sq_locked", locked, 1);
      check("sq_period", period, 80);
      check("sq_max", max_val, 200);
      check("sq_min", min_val, 50);
      check("sq_pkpk", pk_pk, 150);

      // Asynchronous reset during an active stream, checked before any clock edge
      for (int k = 0; k < 50; k++) step((k < 40) ? 200 : 50, 1'b1);
      rst = 1'b1;
      #1;
      check_reset_outputs("midrst");
      model_reset();
      have_last = 0;
      rv_count = 0;
      @(posedge clk); #1;
      rst = 1'b0;

      // First sample high: no event until a dip to <=120 and a return to >=136
      for (int k = 0; k < 5; k++) step(250, 1'b1);
      step(130, 1'b1);
      step(121, 1'b1);
      step(140, 1'b1);
      step(120, 1'b1);
      step(136, 1'b1);
      step(136, 1'b0);
      step(136, 1'b0);
      check("no_result_before_2nd", rv_count, 0);
      check("not_locked_yet", locked, 0);

      // Sine table
      for (int p = 0; p < 6; p++)
         for (int i = 0; i < 32; i++) step(sine_tab[i], 1'b1);
      check("sine_interval", last_int, 32);
      check("sine_period", period, 32);
      check("sine_max", max_val, 255);
      check("sine_min", min_val, 0);
      check("sine_pkpk", pk_pk, 255);
      check("sine_locked", locked, 1);

      // Square wave with sample_valid every other cycle
      square(5, 1'b1);
      check("half_interval", last_int, 160);
      check("half_period", period, 80);

      // Inside the hysteresis band: no events, eventual timeout
      to_count = 0;
      for (int k = 0; k < 4100; k++) step((k % 2 == 0) ? 135 : 121, 1'b1);
      for (int k = 0; k < 3; k++) step(121, 1'b0);
      check("to_count", to_count, 1);
      check("to_locked", locked, 0);
      check("to_period_held", period, 80);
      check("to_max_held", max_val, 200);
      check("to_min_held", min_val, 50);

      // Back in SEARCH: one rising event alone produces no result
      rv_count = 0;
      step(200, 1'b1);
      for (int k = 0; k < 10; k++) step(200, 1'b1);
      check("search_no_result", rv_count, 0);

      for (int k = 0; k < 4; k++) step(0, 1'b0);
      check("queue_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
